// File: rtl/iob_pmem_sprite.sv
// Sprite pixel generator: N_OBJ rectangles with shadow/active register sets,
// frame-synchronous commit, a 2-stage pixel pipeline and sticky collision flags.
module iob_pmem_sprite #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 6,
  parameter int N_OBJ      = 4,
  parameter int PIPE_DELAY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  output logic [31:0]       rdata,
  output logic              ready,
  input  logic [9:0]        pmem_pixel_x,
  input  logic [9:0]        pmem_pixel_y,
  input  logic              pmem_pixel_vld,
  input  logic              pmem_frame_start,
  input  logic              pmem_rst_btn,
  output logic [11:0]       pmem_rgb
);

  if (DATA_W != 32 || PIPE_DELAY != 2 || N_OBJ < 1 || N_OBJ > 16 ||
      (1 << ADDR_W) < 2 * N_OBJ + 4) begin : g_param_check
    $error("iob_pmem_sprite: unsupported parameter set");
  end

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(2 * N_OBJ);
  localparam logic [ADDR_W-1:0] A_COLL = ADDR_W'(2 * N_OBJ + 1);
  localparam logic [ADDR_W-1:0] A_FCNT = ADDR_W'(2 * N_OBJ + 2);
  localparam logic [ADDR_W-1:0] A_BTN  = ADDR_W'(2 * N_OBJ + 3);

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Lower bound saturates at 0 so objects near the left/top edge never wrap.
  function automatic logic [10:0] sat_sub(input logic [9:0] pos, input logic [7:0] hlen);
    return ({1'b0, pos} >= {3'b000, hlen}) ? ({1'b0, pos} - {3'b000, hlen}) : 11'd0;
  endfunction

  function automatic logic [10:0] ext_add(input logic [9:0] pos, input logic [7:0] hlen);
    return {1'b0, pos} + {3'b000, hlen};
  endfunction

  function automatic logic obj_hit(input logic [9:0]  px,
                                   input logic [9:0]  py,
                                   input logic [31:0] loc,
                                   input logic [16:0] size);
    logic in_x, in_y;
    in_x = ({1'b0, px} >= sat_sub(loc[9:0], size[7:0])) &&
           ({1'b0, px} <= ext_add(loc[9:0], size[7:0]));
    in_y = ({1'b0, py} >= sat_sub(loc[19:10], size[15:8])) &&
           ({1'b0, py} <= ext_add(loc[19:10], size[15:8]));
    return size[16] && in_x && in_y;
  endfunction

  logic [31:0]      sh_loc   [N_OBJ];
  logic [16:0]      sh_size  [N_OBJ];
  logic [31:0]      act_loc  [N_OBJ];
  logic [16:0]      act_size [N_OBJ];
  logic             auto_commit;
  logic [11:0]      bg_rgb;
  logic [N_OBJ-1:0] coll;
  logic [31:0]      frame_cnt;
  logic             commit_pend;

  logic             accept, wr_en, wr_force, commit;
  logic [31:0]      rd_val, wr_val;
  logic [N_OBJ-1:0] coll_clr, coll_set;

  logic [N_OBJ-1:0] hit_c;
  logic [N_OBJ-1:0] hit_p1;
  logic             vld_p1;
  logic [11:0]      sel_rgb;
  logic             multi_hit;

  assign accept   = valid && !ready;
  assign wr_en    = accept && (wstrb != 4'b0000);
  assign wr_val   = merge_strb(rd_val, wdata, wstrb);
  assign wr_force = wr_en && (address == A_CTRL) && wr_val[1];
  assign commit   = (pmem_frame_start && auto_commit) || commit_pend;
  assign coll_clr = (accept && !wr_en && address == A_COLL) ? '1 : '0;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (address == ADDR_W'(2 * i))     rd_val = sh_loc[i];
      if (address == ADDR_W'(2 * i + 1)) rd_val = 32'(sh_size[i]);
    end
    if (address == A_CTRL) rd_val = {16'h0000, bg_rgb, 3'b000, auto_commit};
    if (address == A_COLL) rd_val = 32'(coll);
    if (address == A_FCNT) rd_val = frame_cnt;
    if (address == A_BTN)  rd_val = {31'h0, pmem_rst_btn};
  end

  // Commit reads the shadow values as they stand before this edge's CPU write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready       <= 1'b0;
      rdata       <= '0;
      auto_commit <= 1'b1;
      bg_rgb      <= '0;
      coll        <= '0;
      frame_cnt   <= '0;
      commit_pend <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
        sh_loc[i]   <= '0;
        sh_size[i]  <= '0;
        act_loc[i]  <= '0;
        act_size[i] <= '0;
      end
    end else begin
      ready       <= accept;
      commit_pend <= wr_force;
      if (accept) rdata <= rd_val;
      if (commit) begin
        frame_cnt <= frame_cnt + 32'd1;
        for (int i = 0; i < N_OBJ; i++) begin
          act_loc[i]  <= sh_loc[i];
          act_size[i] <= sh_size[i];
        end
      end
      if (wr_en) begin
        for (int i = 0; i < N_OBJ; i++) begin
          if (address == ADDR_W'(2 * i))     sh_loc[i]  <= wr_val;
          if (address == ADDR_W'(2 * i + 1)) sh_size[i] <= wr_val[16:0];
        end
        if (address == A_CTRL) begin
          auto_commit <= wr_val[0];
          bg_rgb      <= wr_val[15:4];
        end
      end
      coll <= (coll & ~coll_clr) | coll_set;
    end
  end

  always_comb begin
    hit_c = '0;
    for (int i = 0; i < N_OBJ; i++)
      hit_c[i] = obj_hit(pmem_pixel_x, pmem_pixel_y, act_loc[i], act_size[i]);
  end

  always_comb begin
    sel_rgb = bg_rgb;
    for (int i = N_OBJ - 1; i >= 0; i--)
      if (hit_p1[i]) sel_rgb = act_loc[i][31:20];
  end

  assign multi_hit = (hit_p1 & (hit_p1 - N_OBJ'(1))) != '0;
  assign coll_set  = (vld_p1 && multi_hit) ? hit_p1 : '0;

  // Stage 1 -> stage 2: per-object hit flags and pixel valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_p1   <= '0;
      vld_p1   <= 1'b0;
      pmem_rgb <= '0;
    end else begin
      hit_p1   <= hit_c;
      vld_p1   <= pmem_pixel_vld;
      // Stage 2 output: priority colour select.
      pmem_rgb <= vld_p1 ? sel_rgb : 12'h000;
    end
  end

endmodule
